video_timing_gen: RTL

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 119 +++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with blanking, syncs and four test patterns
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int SYNC_POL = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic        en_i,
  input  logic [1:0]  pat_sel_i,
  output logic [23:0] vid_rgb_o,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output logic [11:0] hcount_o,
  output logic [10:0] vcount_o,
  output logic [7:0]  frame_o,
  output logic        busy_o
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int BAR_W    = H_ACTIVE / 8;
  localparam logic SP     = SYNC_POL != 0;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t      state_q;
  logic [11:0] h_q;
  logic [10:0] v_q;
  logic [7:0]  f_q;
  logic [1:0]  pat_q;
  logic [23:0] rgb_q;
  logic [1:0]  blank_q;
  logic [2:0]  sync_q;
  logic [11:0] hc_q;
  logic [10:0] vc_q;
  logic [7:0]  frame_q;
  logic        busy_q;

  logic        h_end, v_end, sof, hb, vb, hs, vs, idle_clr;
  logic [1:0]  pat;
  logic [2:0]  bar;
  logic [23:0] pix, rgb_d;
  logic [2:0]  sync_d;

  // Decode the pixel described by the current counter values
  always_comb begin
    h_end    = h_q == 12'(H_TOTAL - 1);
    v_end    = v_q == 11'(V_TOTAL - 1);
    sof      = h_q == '0 && v_q == '0;
    pat      = sof ? pat_sel_i : pat_q;
    hb       = h_q >= 12'(H_ACTIVE);
    vb       = v_q >= 11'(V_ACTIVE);
    hs       = h_q >= 12'(HS_START) && h_q < 12'(HS_END);
    vs       = v_q >= 11'(VS_START) && v_q < 11'(VS_END);
    bar      = '0;
    for (int i = 1; i < 8; i++) bar = h_q >= 12'(i * BAR_W) ? 3'(i) : bar;
    pix      = pat == 2'd0 ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} :
               pat == 2'd1 ? {3{h_q[10:3]}} :
               pat == 2'd2 ? {24{h_q[6] ^ v_q[6]}} : 24'hFF5A43;
    rgb_d    = (hb | vb) ? '0 : pix;
    sync_d   = {~(hb | vb), vs ? SP : ~SP, hs ? SP : ~SP};
    idle_clr = rst_i || (cen_i && state_q == IDLE);
  end

  // Run-control FSM, raster counters and registered outputs
  always_ff @(posedge clk_i) begin
    if (idle_clr) begin
      state_q <= (!rst_i && en_i) ? RUN : IDLE;
      h_q     <= '0;
      v_q     <= '0;
      f_q     <= '0;
      pat_q   <= '0;
      rgb_q   <= '0;
      blank_q <= 2'b11;
      sync_q  <= {1'b0, ~SP, ~SP};
      hc_q    <= '0;
      vc_q    <= '0;
      frame_q <= '0;
      busy_q  <= 1'b0;
    end else if (cen_i) begin
      rgb_q   <= rgb_d;
      blank_q <= {vb, hb};
      sync_q  <= sync_d;
      hc_q    <= h_q;
      vc_q    <= v_q;
      frame_q <= f_q;
      busy_q  <= 1'b1;
      pat_q   <= pat;
      h_q     <= h_end ? '0 : h_q + 12'd1;
      v_q     <= h_end ? (v_end ? '0 : v_q + 11'd1) : v_q;
      if (state_q == STOP && !en_i && h_end && v_end) begin
        state_q <= IDLE;
        f_q     <= '0;
      end else begin
        state_q <= en_i ? RUN : STOP;
        f_q     <= (h_end && v_end) ? f_q + 8'd1 : f_q;
      end
    end
  end

  assign vid_rgb_o  = rgb_q;
  assign vh_blank_o = blank_q;
  assign dvh_sync_o = sync_q;
  assign hcount_o   = hc_q;
  assign vcount_o   = vc_q;
  assign frame_o    = frame_q;
  assign busy_o     = busy_q;
endmodule
